// File: rtl/cla_pkg.sv
// Shared constants and 4-bit group propagate/generate helpers for the
// pipelined carry-lookahead adder.
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int ngroups(input int n);
        return n / GROUP_W;
    endfunction

    function automatic logic grp_prop(input logic [3:0] p4);
        return &p4;
    endfunction

    function automatic logic grp_gen(input logic [3:0] p4, input logic [3:0] g4);
        return g4[3]
             | (p4[3] & g4[2])
             | (p4[3] & p4[2] & g4[1])
             | (p4[3] & p4[2] & p4[1] & g4[0]);
    endfunction

endpackage

// File: rtl/gen_signal.sv
// 4-bit group generate: high when the group produces a carry on its own.
module gen_signal
    import cla_pkg::*;
(
    input  logic [3:0] p,
    input  logic [3:0] g,
    output logic       gen
);

    assign gen = grp_gen(p, g);

endmodule

// File: rtl/prop_signal.sv
// 4-bit group propagate: high when every bit of the group propagates.
module prop_signal
    import cla_pkg::*;
(
    input  logic [3:0] p,
    output logic       prop
);

    assign prop = grp_prop(p);

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides:
// stage 1 registers bit/group p/g, stage 2 resolves carries into the output register.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         prop_all
);

    localparam int NG = ngroups(N);

    logic [N-1:0]  p_s;
    logic [N-1:0]  g_s;
    logic [NG-1:0] grp_p_s;
    logic [NG-1:0] grp_g_s;

    logic [N-1:0]  s1_p_r;
    logic [N-1:0]  s1_g_r;
    logic [NG-1:0] s1_gp_r;
    logic [NG-1:0] s1_gg_r;
    logic          s1_cin_r;
    logic          s1_valid_r;

    logic [N-1:0]  sum_s;
    logic          cout_s;
    logic          prop_all_s;

    logic [N-1:0]  sum_r;
    logic          cout_r;
    logic          prop_all_r;
    logic          out_valid_r;

    logic          s2_ready_s;
    logic          in_xfer_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        prop_signal u_prop (
            .p    (p_s[4*k +: 4]),
            .prop (grp_p_s[k])
        );
        gen_signal u_gen (
            .p   (p_s[4*k +: 4]),
            .g   (g_s[4*k +: 4]),
            .gen (grp_g_s[k])
        );
    end

    assign s2_ready_s = ~out_valid_r | out_ready;
    assign in_ready   = ~s1_valid_r | s2_ready_s;
    assign in_xfer_s  = in_valid & in_ready;

    // Stage 1 register: captures p/g terms on input transfer, empties on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_p_r     <= '0;
            s1_g_r     <= '0;
            s1_gp_r    <= '0;
            s1_gg_r    <= '0;
            s1_cin_r   <= 1'b0;
            s1_valid_r <= 1'b0;
        end else if (in_xfer_s) begin
            s1_p_r     <= p_s;
            s1_g_r     <= g_s;
            s1_gp_r    <= grp_p_s;
            s1_gg_r    <= grp_g_s;
            s1_cin_r   <= cin;
            s1_valid_r <= 1'b1;
        end else if (s2_ready_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Carry resolution: flat lookahead within each 16-bit block, block carries ripple.
    always_comb begin
        logic [NG:0]  gc_v;
        logic [N-1:0] bc_v;
        logic         prod_v;
        logic         car_v;
        int           blk_v;
        int           idx_v;

        gc_v    = '0;
        bc_v    = '0;
        gc_v[0] = s1_cin_r;
        for (int k = 0; k < NG; k++) begin
            blk_v  = (k / 4) * 4;
            prod_v = 1'b1;
            car_v  = 1'b0;
            for (int j = 0; j < 4; j++) begin
                idx_v = k - j;
                if (idx_v >= blk_v) begin
                    car_v  = car_v | (prod_v & s1_gg_r[idx_v]);
                    prod_v = prod_v & s1_gp_r[idx_v];
                end else begin
                    car_v  = car_v;
                    prod_v = prod_v;
                end
            end
            gc_v[k+1] = car_v | (prod_v & gc_v[blk_v]);
        end

        // Bit carries inside each group from the group's incoming carry.
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < 4; i++) begin
                prod_v = 1'b1;
                car_v  = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    idx_v = 4*k + i - 1 - j;
                    if (j < i) begin
                        car_v  = car_v | (prod_v & s1_g_r[idx_v]);
                        prod_v = prod_v & s1_p_r[idx_v];
                    end else begin
                        car_v  = car_v;
                        prod_v = prod_v;
                    end
                end
                bc_v[4*k + i] = car_v | (prod_v & gc_v[k]);
            end
        end

        sum_s      = s1_p_r ^ bc_v;
        cout_s     = gc_v[NG];
        prop_all_s = &s1_gp_r;
    end

    // Output register: loads whenever stage 2 can accept, holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r       <= '0;
            cout_r      <= 1'b0;
            prop_all_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (s2_ready_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                sum_r      <= sum_s;
                cout_r     <= cout_s;
                prop_all_r <= prop_all_s;
            end
        end
    end

    assign sum       = sum_r;
    assign cout      = cout_r;
    assign prop_all  = prop_all_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: expected results queued on input
// transfer and compared in order on output transfer.
module tb_cla_pipe_adder;

    localparam int N = 16;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         p;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         prop_all;

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .prop_all  (prop_all)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic);
        exp_t         e;
        logic [N:0]   t;
        t   = {1'b0, ia} + {1'b0, ib} + {{N{1'b0}}, ic};
        e.s = t[N-1:0];
        e.c = t[N];
        e.p = &(ia ^ ib);
        return e;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check_val("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check_val("sum", sum, e.s);
                    check_val("cout", cout, e.c);
                    check_val("prop_all", prop_all, e.p);
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin));
        end
    end

    task automatic send(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ic);
        logic ok;
        ok       = 1'b0;
        a        = ia;
        b        = ib;
        cin      = ic;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check_val("accept_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check_val("drain", q.size(), 64'd0);
    endtask

    initial begin
        int   nacc;
        int   n0;
        logic acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_val("rst_out_valid", out_valid, 64'd0);
        check_val("rst_sum", sum, 64'd0);
        check_val("rst_cout", cout, 64'd0);
        check_val("rst_prop_all", prop_all, 64'd0);
        check_val("rst_in_ready", in_ready, 64'd1);

        // Latency: result visible after the second edge counting the accept edge.
        send(16'hFFFF, 16'h0001, 1'b0);
        check_val("lat_early", out_valid, 64'd0);
        @(posedge clk);
        #1;
        check_val("lat_valid", out_valid, 64'd1);
        check_val("lat_sum", sum, 64'h0000);
        check_val("lat_cout", cout, 64'd1);
        drain();

        send(16'h1234, 16'h4321, 1'b1);
        send(16'hAAAA, 16'h5555, 1'b1);
        drain();

        // Back-to-back: three results on consecutive cycles.
        n0 = n_out;
        send(16'h0001, 16'h0001, 1'b0);
        send(16'h0002, 16'h0002, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
        check_val("b2b_v0", out_valid, 64'd1);
        @(posedge clk);
        #1;
        check_val("b2b_v1", out_valid, 64'd1);
        @(posedge clk);
        #1;
        check_val("b2b_v2", out_valid, 64'd0);
        drain();
        check_val("b2b_count", n_out - n0, 64'd3);

        // Stall: only two operations fit while the consumer is blocked.
        n0        = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h0001;
        b         = 16'h0002;
        cin       = 1'b0;
        nacc      = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                nacc++;
                a = a + 16'd10;
            end
        end
        check_val("stall_accepts", nacc, 64'd2);
        check_val("stall_in_ready", in_ready, 64'd0);
        check_val("stall_valid", out_valid, 64'd1);
        check_val("stall_sum", sum, q[0].s);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check_val("stall_count", n_out - n0, 64'd2);

        // Reset with two operations in flight.
        out_ready = 1'b0;
        send(16'h0005, 16'h0006, 1'b0);
        send(16'h0007, 16'h0008, 1'b0);
        check_val("pre_rst_valid", out_valid, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("post_rst_valid", out_valid, 64'd0);
        check_val("post_rst_sum", sum, 64'd0);
        check_val("post_rst_in_ready", in_ready, 64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("post_rst_idle", out_valid, 64'd0);

        // Random operands with random backpressure.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
